// File: rtl/muxn_pipe.sv
// N-input WIDTH-bit selector with a registered output and a 2-entry skid buffer.
// in_ready and out_valid come straight from state flops, so no ready path runs through the block.
module muxn_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    select,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   y,
  output logic               sel_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         count
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] skid_d;
  logic             skid_err;
  logic [WIDTH-1:0] cap_data;
  logic             cap_err;
  logic             sel_ok;
  logic             acc;
  logic             drn;

  assign count     = state;
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_SKID);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  assign sel_ok  = ({{(32-SELW){1'b0}}, select} < 32'(N));
  assign cap_err = ~sel_ok;

  // Explicit compare per input keeps out-of-range selects at zero for non-power-of-two N.
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < N; i++) begin
      if (select == SELW'(i)) cap_data = d[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state    <= ST_EMPTY;
      y        <= '0;
      sel_err  <= 1'b0;
      skid_d   <= '0;
      skid_err <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            state   <= ST_FULL;
            y       <= cap_data;
            sel_err <= cap_err;
          end
        end
        ST_FULL: begin
          if (acc && drn) begin
            y       <= cap_data;
            sel_err <= cap_err;
          end else if (acc) begin
            state    <= ST_SKID;
            skid_d   <= cap_data;
            skid_err <= cap_err;
          end else if (drn) begin
            state <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drn) begin
            state   <= ST_FULL;
            y       <= skid_d;
            sel_err <= skid_err;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_muxn_pipe.sv
// Bench for muxn_pipe: directed cases on N=4 and N=5, then a scoreboarded random soak on N=8.
module tb_muxn_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=4 instance
  logic [127:0] d4 = '0;
  logic [1:0]   sel4 = '0;
  logic         iv4 = 0, fl4 = 0, or4 = 0;
  logic         ir4, e4, ov4;
  logic [31:0]  y4;
  logic [1:0]   cnt4;

  // N=5 instance
  logic [159:0] d5 = '0;
  logic [2:0]   sel5 = '0;
  logic         iv5 = 0, fl5 = 0, or5 = 0;
  logic         ir5, e5, ov5;
  logic [31:0]  y5;
  logic [1:0]   cnt5;

  // N=8 instance
  logic [255:0] d8 = '0;
  logic [2:0]   sel8 = '0;
  logic         iv8 = 0, fl8 = 0, or8 = 0;
  logic         ir8, e8, ov8;
  logic [31:0]  y8;
  logic [1:0]   cnt8;

  muxn_pipe #(.WIDTH(32), .N(4)) u4 (
    .clk(clk), .reset(rst), .d(d4), .select(sel4), .in_valid(iv4), .in_ready(ir4),
    .flush(fl4), .y(y4), .sel_err(e4), .out_valid(ov4), .out_ready(or4), .count(cnt4)
  );
  muxn_pipe #(.WIDTH(32), .N(5)) u5 (
    .clk(clk), .reset(rst), .d(d5), .select(sel5), .in_valid(iv5), .in_ready(ir5),
    .flush(fl5), .y(y5), .sel_err(e5), .out_valid(ov5), .out_ready(or5), .count(cnt5)
  );
  muxn_pipe #(.WIDTH(32), .N(8)) u8 (
    .clk(clk), .reset(rst), .d(d8), .select(sel8), .in_valid(iv8), .in_ready(ir8),
    .flush(fl8), .y(y8), .sel_err(e8), .out_valid(ov8), .out_ready(or8), .count(cnt8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard entries are {sel_err, data}.
  logic [32:0] sbq[$];
  localparam int SoakCycles = 10000;
  localparam int DrainCycles = 4;

  task automatic soak_driver();
    logic [31:0] w[8];
    logic        ir_s;
    for (int c = 0; c < SoakCycles + DrainCycles; c++) begin
      @(negedge clk);
      if (c < SoakCycles) begin
        iv8 = ($urandom_range(0, 9) < 6);
        or8 = 1'($urandom_range(0, 1));
        fl8 = ($urandom_range(0, 99) == 0);
      end else begin
        iv8 = 1'b0;
        or8 = 1'b1;
        fl8 = 1'b0;
      end
      sel8 = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) begin
        w[k] = $urandom;
        d8[k*32 +: 32] = w[k];
      end
      #1;
      if (iv8 && ir8 && !fl8) sbq.push_back({1'b0, w[sel8]});
      #2;
      // Toggling out_ready mid-cycle must not move in_ready.
      ir_s = ir8;
      or8 = ~or8;
      #1;
      chk("in_ready_comb", 64'(ir8), 64'(ir_s));
      or8 = ~or8;
    end
  endtask

  task automatic soak_monitor();
    logic [32:0] exp;
    for (int c = 0; c < SoakCycles + DrainCycles; c++) begin
      @(negedge clk);
      #2;
      if (ov8 && or8) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL soak_extra: got %0h expected no output", {e8, y8});
        end else begin
          exp = sbq.pop_front();
          chk("soak_out", 64'({e8, y8}), 64'(exp));
        end
      end
      if (fl8) sbq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'h1111_1111 * i;
    for (int i = 0; i < 5; i++) d5[i*32 +: 32] = 32'h1111_1111 * i;
    repeat (2) tick();
    chk("rst_out_valid", 64'(ov4), 64'd0);
    chk("rst_in_ready", 64'(ir4), 64'd1);
    chk("rst_count", 64'(cnt4), 64'd0);
    chk("rst_y", 64'(y4), 64'd0);
    rst = 1'b0;

    // Streaming
    or4 = 1'b1;
    iv4 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      tick();
      chk("stream_y", 64'(y4), 64'(32'h1111_1111 * s));
      chk("stream_err", 64'(e4), 64'd0);
      chk("stream_ov", 64'(ov4), 64'd1);
      chk("stream_ir", 64'(ir4), 64'd1);
      chk("stream_cnt", 64'(cnt4), 64'd1);
    end
    iv4 = 1'b0;
    tick();
    chk("stream_drained", 64'(cnt4), 64'd0);

    // Stall into skid
    or4 = 1'b0;
    iv4 = 1'b1;
    sel4 = 2'd1;
    tick();
    chk("stall_cnt1", 64'(cnt4), 64'd1);
    sel4 = 2'd3;
    tick();
    chk("stall_cnt2", 64'(cnt4), 64'd2);
    chk("stall_ir", 64'(ir4), 64'd0);
    chk("stall_y_held", 64'(y4), 64'h1111_1111);
    iv4 = 1'b0;
    tick();
    chk("stall_y_still", 64'(y4), 64'h1111_1111);
    or4 = 1'b1;
    tick();
    chk("unstall_y", 64'(y4), 64'h3333_3333);
    chk("unstall_cnt", 64'(cnt4), 64'd1);
    chk("unstall_ir", 64'(ir4), 64'd1);
    tick();
    chk("unstall_empty", 64'(cnt4), 64'd0);

    // Flush while in SKID, with a live input offered
    or4 = 1'b0;
    iv4 = 1'b1;
    sel4 = 2'd1;
    tick();
    sel4 = 2'd2;
    tick();
    chk("flush_pre_cnt", 64'(cnt4), 64'd2);
    sel4 = 2'd3;
    fl4 = 1'b1;
    tick();
    chk("flush_cnt", 64'(cnt4), 64'd0);
    chk("flush_ov", 64'(ov4), 64'd0);
    chk("flush_y", 64'(y4), 64'd0);
    chk("flush_ir", 64'(ir4), 64'd1);
    fl4 = 1'b0;
    iv4 = 1'b0;
    or4 = 1'b1;
    tick();
    chk("flush_dropped", 64'(ov4), 64'd0);

    // Reset mid-operation together with flush and in_valid
    or4 = 1'b0;
    iv4 = 1'b1;
    sel4 = 2'd1;
    tick();
    sel4 = 2'd2;
    tick();
    chk("rst2_pre_cnt", 64'(cnt4), 64'd2);
    rst = 1'b1;
    fl4 = 1'b1;
    sel4 = 2'd3;
    tick();
    chk("rst2_ov", 64'(ov4), 64'd0);
    chk("rst2_ir", 64'(ir4), 64'd1);
    chk("rst2_cnt", 64'(cnt4), 64'd0);
    chk("rst2_y", 64'({e4, y4}), 64'd0);
    rst = 1'b0;
    fl4 = 1'b0;
    or4 = 1'b1;
    sel4 = 2'd2;
    tick();
    chk("rst2_first_ov", 64'(ov4), 64'd1);
    chk("rst2_first_y", 64'(y4), 64'h2222_2222);
    iv4 = 1'b0;

    // Out-of-range select on N=5
    or5 = 1'b1;
    iv5 = 1'b1;
    sel5 = 3'd7;
    tick();
    chk("oor_y", 64'(y5), 64'd0);
    chk("oor_err", 64'(e5), 64'd1);
    chk("oor_ov", 64'(ov5), 64'd1);
    sel5 = 3'd4;
    tick();
    chk("sel4_err", 64'(e5), 64'd0);
    chk("sel4_y", 64'(y5), 64'h4444_4444);
    sel5 = 3'd5;
    tick();
    chk("sel5_err", 64'(e5), 64'd1);
    iv5 = 1'b0;

    // Random soak on N=8
    fork
      soak_driver();
      soak_monitor();
    join
    chk("soak_sb_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
